// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Latency: start sampled at edge E0, result on hi/lo with a done pulse after edge E32.
//          A new start is accepted in the done cycle.
// Backpressure: none. start is ignored while busy=1. MTHI/MTLO writes are ignored while busy=1
//               or when start is asserted in the same cycle.
// Ports: clk, reset (sync, active-high); start/op/op_a/op_b launch an operation;
//        hi_we/lo_we/wdata give direct HI/LO writes; busy/done report status; hi/lo hold the results.
module mips_cpu_muldiv (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t      r_state, w_state_nxt;
   logic [5:0]  r_cnt;
   logic        r_is_div;
   logic        r_neg_q;       // negate product / quotient at the end
   logic        r_neg_r;       // negate remainder (dividend was negative)
   logic [31:0] r_acc;         // product high half / partial remainder
   logic [31:0] r_q;           // multiplier shifting out / dividend shifting into quotient
   logic [31:0] r_m;           // multiplicand magnitude / divisor magnitude
   logic [31:0] r_a;           // raw dividend, returned as remainder on divide by zero
   logic [31:0] r_hi, r_lo;
   logic        r_done;

   logic        w_start, w_last;
   logic        w_signed, w_a_neg, w_b_neg;
   logic [31:0] w_a_mag, w_b_mag;
   logic [32:0] w_sum, w_shl;
   logic [33:0] w_diff;
   logic [31:0] w_acc_nxt, w_q_nxt;
   logic [63:0] w_prod, w_prod_s;
   logic [31:0] w_quo, w_rem;

   assign w_start = (r_state == S_IDLE) && start;
   assign w_last  = (r_state == S_RUN) && (r_cnt == 6'd31);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (start)            w_state_nxt = S_RUN;
         S_RUN:  if (r_cnt == 6'd31)   w_state_nxt = S_IDLE;
         default:                      w_state_nxt = S_IDLE;
      endcase
   end

   // Signed ops (MULT, DIV) have op[0]=0; the core always works on magnitudes.
   assign w_signed = ~op[0];
   assign w_a_neg  = w_signed & op_a[31];
   assign w_b_neg  = w_signed & op_b[31];
   assign w_a_mag  = w_a_neg ? -op_a : op_a;
   assign w_b_mag  = w_b_neg ? -op_b : op_b;

   // One iteration of shift-add multiply or restoring divide.
   // Multiply: {acc,q} shifts right, adding m to the top half when the multiplier LSB is set.
   // Divide: {acc,q} shifts left one bit, trial-subtract m and keep the difference if it is non-negative.
   assign w_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : 33'd0);
   assign w_shl  = {r_acc, r_q[31]};
   assign w_diff = {1'b0, w_shl} - {2'b00, r_m};

   always_comb begin
      w_acc_nxt = w_sum[32:1];
      w_q_nxt   = {w_sum[0], r_q[31:1]};
      if (r_is_div) begin
         // Restored value fits 32 bits because it is below the divisor.
         w_acc_nxt = w_diff[33] ? w_shl[31:0] : w_diff[31:0];
         w_q_nxt   = {r_q[30:0], ~w_diff[33]};
      end
   end

   assign w_prod   = {w_acc_nxt, w_q_nxt};
   assign w_prod_s = r_neg_q ? -w_prod : w_prod;
   assign w_quo    = r_neg_q ? -w_q_nxt : w_q_nxt;
   assign w_rem    = r_neg_r ? -w_acc_nxt : w_acc_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= 6'd0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_acc    <= 32'd0;
         r_q      <= 32'd0;
         r_m      <= 32'd0;
         r_a      <= 32'd0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_start) begin
            r_cnt    <= 6'd0;
            r_is_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_acc    <= 32'd0;
            r_q      <= op[1] ? w_a_mag : w_b_mag;
            r_m      <= op[1] ? w_b_mag : w_a_mag;
            r_a      <= op_a;
         end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
               r_done <= 1'b1;
               if (!r_is_div) begin
                  r_hi <= w_prod_s[63:32];
                  r_lo <= w_prod_s[31:0];
               end else if (r_m == 32'd0) begin
                  // Divide by zero: all-ones quotient, dividend passed through untouched.
                  r_hi <= r_a;
                  r_lo <= 32'hFFFF_FFFF;
               end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end
            end
         end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
         end
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv: directed and chained random checks of the HI/LO multiply/divide unit.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected results come from hand-computed constants and a 64-bit arithmetic reference.
module tb_mips_cpu_muldiv;

   logic        clk = 1'b0;
   logic        reset, start, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] op_a, op_b, wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] m_hi, m_lo;   // bench's own view of HI/LO

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   mips_cpu_muldiv dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      int     ia, ib;
      logic [63:0] ua, ub;
      ref_model = 64'd0;
      case (o)
         MULT: begin
            sa = $signed(a);
            sb = $signed(b);
            ref_model = sa * sb;
         end
         MULTU: begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            ref_model = ua * ub;
         end
         DIV: begin
            if (b == 32'd0)
               ref_model = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               ref_model = {32'd0, 32'h8000_0000};
            else begin
               ia = $signed(a);
               ib = $signed(b);
               ref_model = {ia % ib, ia / ib};
            end
         end
         default: begin
            if (b == 32'd0) ref_model = {a, 32'hFFFF_FFFF};
            else            ref_model = {a % b, a / b};
         end
      endcase
   endfunction

   // Pulse start for one edge; the unit must be busy afterwards.
   task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; op_a = a; op_b = b; start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", {63'd0, busy}, 64'd1);
   endtask

   // Wait (bounded) for done; check latency, HI/LO held during RUN, and the result.
   // inj=1 pokes MTLO, a second start and operand changes into the middle of the run.
   task automatic wait_done(input string tag, input logic [63:0] exp, input bit inj);
      int n;
      bit busy_bad, hold_bad;
      n = 0; busy_bad = 0; hold_bad = 0;
      while (done !== 1'b1 && n < 40) begin
         if (busy !== 1'b1) busy_bad = 1;
         if (hi !== m_hi || lo !== m_lo) hold_bad = 1;
         if (inj && n == 5) begin
            lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
            start = 1'b1; op_a = ~op_a; op_b = 32'd0; op = DIVU;
         end
         if (inj && n == 6) begin
            lo_we = 1'b0; hi_we = 1'b0; start = 1'b0;
         end
         tick();
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'd32);
      chk({tag, "_busy_run"}, {63'd0, busy_bad}, 64'd0);
      chk({tag, "_hold"}, {63'd0, hold_bad}, 64'd0);
      chk({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
      chk({tag, "_hilo"}, {hi, lo}, exp);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
   endtask

   initial begin
      int dones;
      logic [1:0]  ro;
      logic [31:0] ra, rb;

      reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'b00; op_a = 32'd0; op_b = 32'd0; wdata = 32'd0;
      m_hi = 32'd0; m_lo = 32'd0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);

      // MTHI / MTLO in IDLE
      hi_we = 1'b1; wdata = 32'h1234_5678;
      tick();
      hi_we = 1'b0;
      chk("mthi", {32'd0, hi}, 64'h1234_5678);
      lo_we = 1'b1; wdata = 32'hCAFE_BABE;
      tick();
      lo_we = 1'b0;
      chk("mtlo", {32'd0, lo}, 64'hCAFE_BABE);
      m_hi = 32'h1234_5678; m_lo = 32'hCAFE_BABE;

      // start wins over MTHI/MTLO in the same cycle; MTLO/start/operand changes during RUN ignored
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_5555;
      start_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      hi_we = 1'b0; lo_we = 1'b0;
      wait_done("multu_max", 64'hFFFF_FFFE_0000_0001, 1'b1);
      dones = 0;
      for (int i = 0; i < 36; i++) begin
         tick();
         if (done === 1'b1) dones++;
      end
      chk("no_extra_done", 64'(dones), 64'd0);
      chk("no_extra_busy", {63'd0, busy}, 64'd0);
      chk("hilo_after_idle", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      start_op(MULT, 32'hFFFF_FFFD, 32'd7);
      wait_done("mult_neg", 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
      tick();
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      start_op(DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done("div_neg", 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
      start_op(DIVU, 32'd100, 32'd0);
      wait_done("divu_zero", {32'd100, 32'hFFFF_FFFF}, 1'b0);
      start_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", {32'd0, 32'h8000_0000}, 1'b0);
      start_op(DIV, 32'h8000_0001, 32'd0);
      wait_done("div_zero", {32'h8000_0001, 32'hFFFF_FFFF}, 1'b0);
      start_op(DIV, 32'd7, 32'hFFFF_FFFE);
      wait_done("div_negb", {32'd1, 32'hFFFF_FFFD}, 1'b0);

      // Reset during RUN cycle 10 aborts with no done
      start_op(MULTU, 32'd1234, 32'd5678);
      for (int i = 0; i < 9; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_hilo", {hi, lo}, 64'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      dones = 0;
      for (int i = 0; i < 36; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) dones++;
      end
      chk("abort_no_done", 64'(dones), 64'd0);
      start_op(MULTU, 32'd3, 32'd5);
      wait_done("after_abort", 64'd15, 1'b0);

      // Back-to-back chain: each start issued in the previous done cycle
      start_op(MULTU, 32'd2, 32'd3);
      wait_done("b2b_first", 64'd6, 1'b0);
      for (int i = 0; i < 8; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 3) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 1000)) : $urandom);
         start_op(ro, ra, rb);
         wait_done($sformatf("rand%0d", i), ref_model(ro, ra, rb), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
